// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000-style asynchronous bus.
// Holds the active-low strobe/acknowledge encodings, the RW encoding and the
// state type used by the memory responder FSM.
package m68k_bus_pkg;

    localparam logic DS_ON     = 1'b0;
    localparam logic DS_OFF    = 1'b1;
    localparam logic AS_STROBE = 1'b0;
    localparam logic AS_OFF    = 1'b1;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;
    localparam logic DTACK_ON  = 1'b0;
    localparam logic DTACK_OFF = 1'b1;
    localparam logic BERR_ON   = 1'b0;
    localparam logic BERR_OFF  = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck,
        StErr
    } resp_state_e;

endpackage

// File: rtl/m68k_mem_responder_if.sv
// Control/handshake side of the 68000-style bus (the data bus D stays a plain
// inout on the responder so the tristate resolves on a single net).
//   A      word address A[23:1] (vector bit k = bus bit k+1)
//   AS     address strobe, active-low
//   UDS    upper byte strobe, active-low
//   LDS    lower byte strobe, active-low
//   RW     1 = read, 0 = write
//   DTACK  data acknowledge, active-low
//   BERR   bus error, active-low
// Modports: master = CPU side, slave = responder side.
interface m68k_mem_responder_if;
    logic [22:0] A;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic        DTACK;
    logic        BERR;

    modport master (output A, AS, UDS, LDS, RW, input DTACK, BERR);
    modport slave  (input A, AS, UDS, LDS, RW, output DTACK, BERR);
endinterface

// File: rtl/byte_lane_ram.sv
// Word RAM with independent byte-lane write enables.
//   CLK    clock, all accesses on posedge
//   addr   word index
//   wdata  write data
//   we     write strobe; be[1] selects [15:8], be[0] selects [7:0]
//   re     read strobe; rdata registers mem[addr] on the same edge
//   rdata  registered read data
// Contents are undefined at power-up and are never cleared.
module byte_lane_ram #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 CLK,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    input  logic                 we,
    input  logic [1:0]           be,
    input  logic                 re,
    output logic [15:0]          rdata
);

    logic [15:0] mem [0:(1 << ADDR_BITS) - 1];

    always_ff @(posedge CLK) begin
        if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
        if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (re)          rdata           <= mem[addr];
    end

endmodule

// File: rtl/m68k_mem_responder.sv
// Bus-side memory slave for the 68000-style asynchronous bus. Decodes a window
// of 2^ADDR_BITS words at BASE, waits WAIT_STATES cycles, then acknowledges
// with DTACK and serves 16-bit reads / byte-laned writes from internal RAM.
//   CLK    clock
//   RESET  synchronous, active-high
//   bus    handshake signals (slave modport)
//   D      16-bit data bus; driven only while acknowledging a read
// Optional feature: define M68K_RESP_BERR_EN to answer window misses with BERR
// (ERR state). Without it a miss is silently dropped and BERR is tied high.
module m68k_mem_responder
    import m68k_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 10,
    parameter logic [22:0] BASE        = 23'h000000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    m68k_mem_responder_if.slave    bus,
    inout  wire  [15:0]            D
);

    resp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [22:0] a_q;
    logic        rw_q, uds_q, lds_q;
    logic        dtack_q, dtack_d;
    logic        d_oe_q, d_oe_d;
    logic        capture, ram_we, ram_re;
    logic        req, hit;
    logic [15:0] ram_rdata;
`ifdef M68K_RESP_BERR_EN
    logic        berr_q, berr_d;
`endif

    assign req = (bus.AS == AS_STROBE) && ((bus.UDS == DS_ON) || (bus.LDS == DS_ON));
    // Decode from the latched address so mid-cycle bus changes are ignored.
    assign hit = (a_q[22:ADDR_BITS] == BASE[22:ADDR_BITS]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dtack_d = dtack_q;
        d_oe_d  = d_oe_q;
        capture = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
`ifdef M68K_RESP_BERR_EN
        berr_d  = berr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_STATES[3:0];
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.AS == AS_OFF) begin
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (hit) begin
                    state_d = StAck;
                    dtack_d = DTACK_ON;
                    if (rw_q == RW_READ) begin
                        ram_re = 1'b1;
                        d_oe_d = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                    end
                end else begin
`ifdef M68K_RESP_BERR_EN
                    state_d = StErr;
                    berr_d  = BERR_ON;
`else
                    state_d = StIdle;
`endif
                end
            end
            StAck: begin
                if (bus.AS == AS_OFF) begin
                    state_d = StIdle;
                    dtack_d = DTACK_OFF;
                    d_oe_d  = 1'b0;
                end
            end
`ifdef M68K_RESP_BERR_EN
            StErr: begin
                if (bus.AS == AS_OFF) begin
                    state_d = StIdle;
                    berr_d  = BERR_OFF;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            dtack_q <= DTACK_OFF;
            d_oe_q  <= 1'b0;
            a_q     <= 23'd0;
            rw_q    <= RW_READ;
            uds_q   <= DS_OFF;
            lds_q   <= DS_OFF;
`ifdef M68K_RESP_BERR_EN
            berr_q  <= BERR_OFF;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dtack_q <= dtack_d;
            d_oe_q  <= d_oe_d;
`ifdef M68K_RESP_BERR_EN
            berr_q  <= berr_d;
`endif
            if (capture) begin
                a_q   <= bus.A;
                rw_q  <= bus.RW;
                uds_q <= bus.UDS;
                lds_q <= bus.LDS;
            end
        end
    end

    // Reset on the commit edge discards the write.
    byte_lane_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .CLK   (CLK),
        .addr  (a_q[ADDR_BITS-1:0]),
        .wdata (D),
        .we    (ram_we && !RESET),
        .be    ({uds_q == DS_ON, lds_q == DS_ON}),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    assign bus.DTACK = dtack_q;
`ifdef M68K_RESP_BERR_EN
    assign bus.BERR  = berr_q;
`else
    assign bus.BERR  = BERR_OFF;
`endif
    assign D = d_oe_q ? ram_rdata : {16{1'bz}};

endmodule

// File: tb/tb_m68k_mem_responder.sv
// Directed bench for m68k_mem_responder. Instance 1 uses WAIT_STATES=2,
// instance 2 uses WAIT_STATES=0. Both data buses carry pull-ups, so a released
// bus reads 16'hFFFF.
module tb_m68k_mem_responder;
    import m68k_bus_pkg::*;

    localparam int WS1   = 2;
    localparam int WS2   = 0;
    localparam int BOUND = 10;
    localparam logic [15:0] REL = 16'hFFFF;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    m68k_mem_responder_if b1();
    m68k_mem_responder_if b2();

    wire  [15:0] d1, d2;
    logic        oe1, oe2;
    logic [15:0] tb_d1, tb_d2;
    assign d1 = oe1 ? tb_d1 : {16{1'bz}};
    assign d2 = oe2 ? tb_d2 : {16{1'bz}};

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (d1[i]);
        pullup (d2[i]);
    end

    m68k_mem_responder #(.ADDR_BITS(10), .BASE(23'h000000), .WAIT_STATES(WS1)) u_dut1 (
        .CLK (CLK), .RESET (RESET), .bus (b1), .D (d1)
    );
    m68k_mem_responder #(.ADDR_BITS(10), .BASE(23'h000000), .WAIT_STATES(WS2)) u_dut2 (
        .CLK (CLK), .RESET (RESET), .bus (b2), .D (d2)
    );

    int checks = 0;
    int errors = 0;

    task automatic drive_idle();
        b1.AS = AS_OFF; b1.UDS = DS_OFF; b1.LDS = DS_OFF; b1.RW = RW_READ; b1.A = '0;
        b2.AS = AS_OFF; b2.UDS = DS_OFF; b2.LDS = DS_OFF; b2.RW = RW_READ; b2.A = '0;
        oe1 = 1'b0; oe2 = 1'b0; tb_d1 = '0; tb_d2 = '0;
    endtask

    function automatic logic responded(input int sel);
        if (sel == 1) return (b1.DTACK == DTACK_ON) || (b1.BERR == BERR_ON);
        return (b2.DTACK == DTACK_ON) || (b2.BERR == BERR_ON);
    endfunction

    // One bus cycle started at a negedge. lat = edges after the sampling edge N
    // until a response is seen (BOUND if none); abort_after>0 raises AS early.
    task automatic bus_cycle(input int sel, input logic [22:0] addr, input logic rw,
                             input logic uds, input logic lds, input logic [15:0] wdata,
                             input int abort_after, output int lat,
                             output logic [15:0] d_ack, output logic dtack_ack,
                             output logic berr_ack, output logic dtack_rel,
                             output logic [15:0] d_rel);
        if (sel == 1) begin
            b1.A = addr; b1.RW = rw; b1.UDS = uds; b1.LDS = lds; b1.AS = AS_STROBE;
            tb_d1 = wdata; oe1 = (rw == RW_WRITE);
        end else begin
            b2.A = addr; b2.RW = rw; b2.UDS = uds; b2.LDS = lds; b2.AS = AS_STROBE;
            tb_d2 = wdata; oe2 = (rw == RW_WRITE);
        end
        lat = 0;
        @(negedge CLK);
        while (!responded(sel) && lat < BOUND && !(abort_after > 0 && lat == abort_after)) begin
            @(negedge CLK);
            lat++;
        end
        d_ack     = (sel == 1) ? d1 : d2;
        dtack_ack = (sel == 1) ? b1.DTACK : b2.DTACK;
        berr_ack  = (sel == 1) ? b1.BERR : b2.BERR;
        drive_idle();
        @(negedge CLK);
        dtack_rel = (sel == 1) ? b1.DTACK : b2.DTACK;
        d_rel     = (sel == 1) ? d1 : d2;
    endtask

    int          lat;
    logic [15:0] d_ack, d_rel;
    logic        dtack_ack, berr_ack, dtack_rel;

    task automatic test_reset();
        RESET = 1'b1;
        drive_idle();
        repeat (2) @(negedge CLK);
        checks++; if (b1.DTACK !== DTACK_OFF) begin errors++; $display("FAIL rst_dtack1 got %b want 1", b1.DTACK); end
        checks++; if (b1.BERR !== BERR_OFF) begin errors++; $display("FAIL rst_berr1 got %b want 1", b1.BERR); end
        checks++; if (d1 !== REL) begin errors++; $display("FAIL rst_d1 got %h want %h", d1, REL); end
        checks++; if (b2.DTACK !== DTACK_OFF) begin errors++; $display("FAIL rst_dtack2 got %b want 1", b2.DTACK); end
        checks++; if (d2 !== REL) begin errors++; $display("FAIL rst_d2 got %h want %h", d2, REL); end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_word_write();
        bus_cycle(1, 23'h000010, RW_WRITE, DS_ON, DS_ON, 16'hBEEF, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        checks++; if (lat != WS1 + 1) begin errors++; $display("FAIL wr_latency got %0d want %0d", lat, WS1 + 1); end
        checks++; if (dtack_rel !== DTACK_OFF) begin errors++; $display("FAIL wr_release got %b want 1", dtack_rel); end
        bus_cycle(1, 23'h000010, RW_READ, DS_ON, DS_ON, 16'h0000, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        checks++; if (lat != WS1 + 1) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, WS1 + 1); end
        checks++; if (d_ack !== 16'hBEEF) begin errors++; $display("FAIL rd_beef got %h want beef", d_ack); end
        checks++; if (berr_ack !== BERR_OFF) begin errors++; $display("FAIL rd_berr got %b want 1", berr_ack); end
        checks++; if (dtack_rel !== DTACK_OFF) begin errors++; $display("FAIL rd_release got %b want 1", dtack_rel); end
        checks++; if (d_rel !== REL) begin errors++; $display("FAIL rd_d_release got %h want %h", d_rel, REL); end
    endtask

    task automatic test_byte_lanes();
        bus_cycle(1, 23'h000010, RW_WRITE, DS_ON, DS_OFF, 16'h12AB, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        bus_cycle(1, 23'h000010, RW_READ, DS_ON, DS_ON, 16'h0000, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        checks++; if (d_ack !== 16'h12EF) begin errors++; $display("FAIL upper_lane got %h want 12ef", d_ack); end
        bus_cycle(1, 23'h000010, RW_WRITE, DS_OFF, DS_ON, 16'h5634, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        bus_cycle(1, 23'h000010, RW_READ, DS_ON, DS_ON, 16'h0000, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        checks++; if (d_ack !== 16'h1234) begin errors++; $display("FAIL lower_lane got %h want 1234", d_ack); end
    endtask

    task automatic test_abort();
        bus_cycle(1, 23'h000010, RW_WRITE, DS_ON, DS_ON, 16'h5555, 1,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        checks++; if (dtack_ack !== DTACK_OFF) begin errors++; $display("FAIL abort_dtack got %b want 1", dtack_ack); end
        checks++; if (dtack_rel !== DTACK_OFF) begin errors++; $display("FAIL abort_rel got %b want 1", dtack_rel); end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if (b1.DTACK !== DTACK_OFF) begin
                errors++; $display("FAIL abort_idle%0d got %b want 1", k, b1.DTACK);
            end
        end
        bus_cycle(1, 23'h000010, RW_READ, DS_ON, DS_ON, 16'h0000, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        checks++; if (d_ack !== 16'h1234) begin errors++; $display("FAIL abort_data got %h want 1234", d_ack); end
    endtask

    task automatic test_miss();
        bus_cycle(1, 23'h100000, RW_READ, DS_ON, DS_ON, 16'h0000, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
`ifdef M68K_RESP_BERR_EN
        checks++; if (lat != WS1 + 1) begin errors++; $display("FAIL miss_latency got %0d want %0d", lat, WS1 + 1); end
        checks++; if (berr_ack !== BERR_ON) begin errors++; $display("FAIL miss_berr got %b want 0", berr_ack); end
        checks++; if (b1.BERR !== BERR_OFF) begin errors++; $display("FAIL miss_berr_rel got %b want 1", b1.BERR); end
`else
        checks++; if (lat != BOUND) begin errors++; $display("FAIL miss_noresp got %0d want %0d", lat, BOUND); end
        checks++; if (berr_ack !== BERR_OFF) begin errors++; $display("FAIL miss_berr got %b want 1", berr_ack); end
`endif
        checks++; if (dtack_ack !== DTACK_OFF) begin errors++; $display("FAIL miss_dtack got %b want 1", dtack_ack); end
        checks++; if (d_ack !== REL) begin errors++; $display("FAIL miss_d got %h want %h", d_ack, REL); end
    endtask

    task automatic test_reset_in_ack();
        b1.A = 23'h000010; b1.RW = RW_READ; b1.UDS = DS_ON; b1.LDS = DS_ON; b1.AS = AS_STROBE;
        lat = 0;
        @(negedge CLK);
        while (b1.DTACK !== DTACK_ON && lat < BOUND) begin @(negedge CLK); lat++; end
        checks++; if (lat != WS1 + 1) begin errors++; $display("FAIL rack_latency got %0d want %0d", lat, WS1 + 1); end
        checks++; if (d1 !== 16'h1234) begin errors++; $display("FAIL rack_data got %h want 1234", d1); end
        RESET = 1'b1;
        @(negedge CLK);
        checks++; if (b1.DTACK !== DTACK_OFF) begin errors++; $display("FAIL rack_dtack got %b want 1", b1.DTACK); end
        checks++; if (d1 !== REL) begin errors++; $display("FAIL rack_d got %h want %h", d1, REL); end
        RESET = 1'b0;
        drive_idle();
        @(negedge CLK);
        bus_cycle(1, 23'h000010, RW_READ, DS_ON, DS_ON, 16'h0000, 0,
                  lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
        checks++; if (lat != WS1 + 1) begin errors++; $display("FAIL post_rst_latency got %0d want %0d", lat, WS1 + 1); end
        checks++; if (d_ack !== 16'h1234) begin errors++; $display("FAIL post_rst_data got %h want 1234", d_ack); end
    endtask

    task automatic test_back_to_back();
        logic [22:0] addrs [4] = '{23'h000020, 23'h000021, 23'h000020, 23'h000021};
        logic [15:0] datas [4] = '{16'h1357, 16'h2468, 16'h1357, 16'h2468};
        for (int k = 0; k < 4; k++) begin
            // First two cycles write, the rest read back.
            bus_cycle(2, addrs[k], (k < 2) ? RW_WRITE : RW_READ, DS_ON, DS_ON, datas[k], 0,
                      lat, d_ack, dtack_ack, berr_ack, dtack_rel, d_rel);
            checks++;
            if (lat != WS2 + 1) begin
                errors++; $display("FAIL b2b_latency%0d got %0d want %0d", k, lat, WS2 + 1);
            end
            if (k >= 2) begin
                checks++;
                if (d_ack !== datas[k]) begin
                    errors++; $display("FAIL b2b_data%0d got %h want %h", k, d_ack, datas[k]);
                end
            end
        end
        checks++; if (d_rel !== REL) begin errors++; $display("FAIL b2b_release got %h want %h", d_rel, REL); end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_lanes();
        test_abort();
        test_miss();
        test_reset_in_ack();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
